instruction_fetch_unit: RTL and testbench

Fetch stage of the MIPS32 pipeline. It owns the program counter and runs a request/ready handshake with instruction memory. It drives the `if_*` inputs of the IF/ID pipeline register: one instruction per cycle with zero-wait memory, stall bubbles on wait states, and branch-delay-slot semantics. It also handles exception flushes. It is the producer side of the IF/ID boundary and honours `id_stall` back-pressure from decode.

---
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS32 fetch stage: owns the PC, handshakes with instruction memory, feeds IF/ID.
// Zero-wait memory gives one instruction per cycle; id_stall parks the word in a one-entry buffer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        annul_delay,
  input  logic        exc_valid,
  input  logic [31:0] exc_vector,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_usable,
  output logic [31:0] if_pc_add_4,
  output logic        if_stall,
  output logic        if_flush,
  output logic        if_bra_delay
);

  typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;

  state_t      state;
  logic        active;
  logic [31:0] pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        pend_annul;
  logic [31:0] disc_addr;

  logic        exc;
  logic        in_req;
  logic        present;
  logic        accept;
  logic        redir_acc;
  logic        annul_acc;
  logic [31:0] next_pc;
  logic [31:0] pres_pc;

  // active stays low until the first edge after reset so imem_req rises on that edge
  always_comb begin
    exc       = exc_valid && active;
    in_req    = active && (state == REQ);
    present   = !exc && ((in_req && imem_ready) || (state == HOLD && buf_valid));
    accept    = present && !id_stall;
    redir_acc = redirect_valid && !id_stall && !exc && active;
    annul_acc = annul_delay && !id_stall && !exc && active;
    if (redir_acc)
      next_pc = redirect_target;
    else if (pend_valid)
      next_pc = pend_target;
    else
      next_pc = pc + 32'd4;
    pres_pc = (state == HOLD) ? buf_pc : pc;
  end

  assign imem_req       = active && (state != HOLD);
  assign imem_addr      = (state == DISCARD) ? {disc_addr[31:2], 2'b00} : {pc[31:2], 2'b00};
  assign if_instruction = !present ? 32'd0 : ((state == HOLD) ? buf_instr : imem_rdata);
  assign if_pc_usable   = pres_pc;
  assign if_pc_add_4    = pres_pc + 32'd4;
  assign if_stall       = !present;
  assign if_flush       = exc;
  assign if_bra_delay   = present && (pend_annul || annul_acc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      active      <= 1'b0;
      pc          <= RESET_VECTOR;
      buf_valid   <= 1'b0;
      buf_instr   <= 32'd0;
      buf_pc      <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
      pend_annul  <= 1'b0;
      disc_addr   <= RESET_VECTOR;
    end else begin
      active <= 1'b1;
      if (exc) begin
        pc         <= exc_vector;
        buf_valid  <= 1'b0;
        pend_valid <= 1'b0;
        pend_annul <= 1'b0;
        // an in-flight transfer must still be completed on the old address and dropped
        if ((in_req || state == DISCARD) && !imem_ready) begin
          state <= DISCARD;
          if (in_req)
            disc_addr <= pc;
        end else begin
          state <= REQ;
        end
      end else begin
        case (state)
          REQ: begin
            if (in_req && imem_ready) begin
              if (!id_stall) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
              end else begin
                buf_valid <= 1'b1;
                buf_instr <= imem_rdata;
                buf_pc    <= pc;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!id_stall) begin
              buf_valid  <= 1'b0;
              pc         <= next_pc;
              pend_valid <= 1'b0;
              state      <= REQ;
            end
          end
          DISCARD: begin
            if (imem_ready)
              state <= REQ;
          end
          default: state <= REQ;
        endcase
        // a redirect seen before its delay slot is delivered waits for that delivery
        if (redir_acc && !accept) begin
          pend_valid  <= 1'b1;
          pend_target <= redirect_target;
        end
        if (accept)
          pend_annul <= 1'b0;
        else if (annul_acc)
          pend_annul <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan steps, then random traffic against a stream-level model.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        annul_delay;
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_usable;
  logic [31:0] if_pc_add_4;
  logic        if_stall;
  logic        if_flush;
  logic        if_bra_delay;

  int checks = 0;
  int errors = 0;
  int deliveries = 0;

  // model of the delivered instruction stream
  logic [31:0] exp_pc;
  logic        m_pv;
  logic [31:0] m_pt;
  logic        m_pa;
  logic        prev_wait;
  logic [31:0] prev_addr;

  instruction_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .annul_delay(annul_delay), .exc_valid(exc_valid), .exc_vector(exc_vector),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_instruction(if_instruction), .if_pc_usable(if_pc_usable), .if_pc_add_4(if_pc_add_4),
    .if_stall(if_stall), .if_flush(if_flush), .if_bra_delay(if_bra_delay)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb imem_rdata = memf(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(negedge clock);
  endtask

  // Sample outputs 1ns after the falling edge and advance the model across the coming rising edge.
  task automatic observe();
    logic racc;
    logic aacc;
    #1;
    if (!reset) begin
      exp_pc    = 32'h0;
      m_pv      = 1'b0;
      m_pa      = 1'b0;
      prev_wait = 1'b0;
      return;
    end
    if (prev_wait) chk("addr_stable", imem_addr, prev_addr);
    prev_wait = imem_req && !imem_ready;
    prev_addr = imem_addr;
    if (exc_valid) begin
      chk("exc_flush", 32'(if_flush), 32'd1);
      chk("exc_stall", 32'(if_stall), 32'd1);
      exp_pc = exc_vector;
      m_pv   = 1'b0;
      m_pa   = 1'b0;
    end else begin
      chk("flush_idle", 32'(if_flush), 32'd0);
      racc = redirect_valid && !id_stall;
      aacc = annul_delay && !id_stall;
      chk("bra_delay", 32'(if_bra_delay), 32'(!if_stall && (m_pa || aacc)));
      if (!if_stall) begin
        chk("pc", if_pc_usable, exp_pc);
        chk("instr", if_instruction, memf(exp_pc));
        chk("pc_add_4", if_pc_add_4, exp_pc + 32'd4);
        if (!id_stall) begin
          deliveries++;
          exp_pc = racc ? redirect_target : (m_pv ? m_pt : exp_pc + 32'd4);
          m_pv   = 1'b0;
          m_pa   = 1'b0;
        end
      end
      if (if_stall || id_stall) begin
        if (racc) begin
          m_pv = 1'b1;
          m_pt = redirect_target;
        end
        if (aacc) m_pa = 1'b1;
      end
    end
  endtask

  initial begin
    int rand_start;
    reset = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    annul_delay = 1'b0; exc_valid = 1'b0; exc_vector = 32'h0; imem_ready = 1'b0;
    exp_pc = 32'h0; m_pv = 1'b0; m_pt = 32'h0; m_pa = 1'b0; prev_wait = 1'b0; prev_addr = 32'h0;

    // reset values
    next();
    observe();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", if_instruction, 32'h0);
    chk("rst_pc", if_pc_usable, 32'h0);
    chk("rst_pc4", if_pc_add_4, 32'h4);
    chk("rst_stall", 32'(if_stall), 32'd1);
    chk("rst_flush", 32'(if_flush), 32'd0);
    chk("rst_bra", 32'(if_bra_delay), 32'd0);
    next();

    // sequential fetch, zero-wait memory
    reset = 1'b1; imem_ready = 1'b1;
    observe(); chk("rel_req", 32'(imem_req), 32'd0); next();
    observe(); chk("seq_req", 32'(imem_req), 32'd1); chk("seq_pc0", if_pc_usable, 32'h0);
    chk("seq_stall0", 32'(if_stall), 32'd0); chk("seq_pc4_0", if_pc_add_4, 32'h4); next();
    observe(); chk("seq_pc1", if_pc_usable, 32'h4); chk("seq_pc4_1", if_pc_add_4, 32'h8); next();

    // two wait states at 0x8
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      observe(); chk("ws_stall", 32'(if_stall), 32'd1); chk("ws_addr", imem_addr, 32'h8); next();
    end
    imem_ready = 1'b1;
    observe(); chk("ws_pc", if_pc_usable, 32'h8); chk("ws_stall_done", 32'(if_stall), 32'd0); next();

    // back-pressure on 0xC
    id_stall = 1'b1;
    observe(); chk("bp_pc_first", if_pc_usable, 32'hC); next();
    for (int i = 0; i < 2; i++) begin
      observe(); chk("bp_req", 32'(imem_req), 32'd0); chk("bp_pc", if_pc_usable, 32'hC);
      chk("bp_stall", 32'(if_stall), 32'd0); next();
    end
    id_stall = 1'b0;
    observe(); chk("bp_release_pc", if_pc_usable, 32'hC); next();
    observe(); chk("bp_next_addr", imem_addr, 32'h10); chk("bp_next_req", 32'(imem_req), 32'd1); next();

    // branch at 0x10 -> 0x40, delay slot 0x14
    redirect_valid = 1'b1; redirect_target = 32'h40;
    observe(); chk("br_slot", if_pc_usable, 32'h14); next();
    redirect_valid = 1'b0;
    observe(); chk("br_target", if_pc_usable, 32'h40); next();
    observe(); chk("bl_branch", if_pc_usable, 32'h44); next();
    annul_delay = 1'b1;
    observe(); chk("bl_slot_pc", if_pc_usable, 32'h48); chk("bl_annul", 32'(if_bra_delay), 32'd1); next();
    annul_delay = 1'b0;
    observe(); chk("bl_after", if_pc_usable, 32'h4C); chk("bl_after_bra", 32'(if_bra_delay), 32'd0); next();

    // branch at 0x50 accepted while its delay slot waits on memory
    observe(); chk("pb_branch", if_pc_usable, 32'h50); next();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h1C;
    observe(); chk("pb_wait", 32'(if_stall), 32'd1); next();
    imem_ready = 1'b1; redirect_valid = 1'b0;
    observe(); chk("pb_slot", if_pc_usable, 32'h54); next();
    observe(); chk("pb_target", if_pc_usable, 32'h1C); next();

    // exception while waiting on 0x20
    imem_ready = 1'b0;
    observe(); chk("ex_wait_addr", imem_addr, 32'h20); next();
    exc_valid = 1'b1; exc_vector = 32'h8000_0180;
    observe(); chk("ex_flush", 32'(if_flush), 32'd1); next();
    exc_valid = 1'b0;
    observe(); chk("ex_disc_req", 32'(imem_req), 32'd1); chk("ex_disc_addr", imem_addr, 32'h20);
    chk("ex_flush_once", 32'(if_flush), 32'd0); next();
    imem_ready = 1'b1;
    observe(); chk("ex_drop", 32'(if_stall), 32'd1); next();
    observe(); chk("ex_handler", if_pc_usable, 32'h8000_0180); chk("ex_handler_addr", imem_addr, 32'h8000_0180); next();
    observe(); chk("ex_handler_next", if_pc_usable, 32'h8000_0184); next();

    // asynchronous reset in the middle of a wait
    imem_ready = 1'b0;
    observe(); chk("mr_req_before", 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0); chk("mr_addr", imem_addr, 32'h0);
    chk("mr_stall", 32'(if_stall), 32'd1); chk("mr_instr", if_instruction, 32'h0);
    next();
    observe(); next();
    reset = 1'b1; imem_ready = 1'b1;
    observe(); next();
    observe(); chk("mr_resume0", if_pc_usable, 32'h0); next();
    observe(); chk("mr_resume1", if_pc_usable, 32'h4); next();

    // random traffic
    rand_start = deliveries;
    for (int i = 0; i < 1500; i++) begin
      imem_ready      = ($urandom_range(0, 9) < 7);
      id_stall        = ($urandom_range(0, 3) == 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom() & 32'hFFFF_FFFC;
      annul_delay     = ($urandom_range(0, 11) == 0);
      exc_valid       = ($urandom_range(0, 32) == 0);
      exc_vector      = $urandom() & 32'hFFFF_FFFC;
      observe();
      next();
    end
    chk("rand_progress", 32'((deliveries - rand_start) >= 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
